// File: rtl/kbd_link_tx.sv
// kbd_link_tx: serializer feeding the keyboard-matrix CPLD over a 3-wire link.
// Holds a 40-key snapshot, tracks which 10-key rows differ from what the CPLD
// last received, and sends 13-bit frames {id[2:0], data[9:0]} MSB first.
// Optional macro KBD_LINK_SHIFT_FAST_EN enables short id-5 frames that update
// only CAPS SHIFT (key 0) and SYMBOL SHIFT (key 36).
//
// Parameters:
//   CLK_DIV         clk cycles per sclk half-period (>= 2)
//   REFRESH_CYCLES  clk cycles between forced full refreshes
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key_state  key matrix, 1 = pressed, bit 10*r+c = row r column c
//   scs_n      link chip select, active-low, rising edge latches the frame
//   sclk       link clock, idles high, CPLD samples sdata on falling edge
//   sdata      link data
//   busy       high from frame load until the end of the inter-frame gap
module kbd_link_tx #(
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned REFRESH_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [39:0] key_state,
   output logic        scs_n,
   output logic        sclk,
   output logic        sdata,
   output logic        busy
);

   localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_BIT_HI, S_BIT_LO, S_END, S_GAP
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [12:0]   shreg;
   logic [39:0]   shadow;
   logic [3:0]    refresh_pend;
   logic [3:0]    dirty_q;
   logic [TW-1:0] ref_cnt;
   logic [1:0]    ptr;
   logic [1:0]    sel_row;
   logic          tick;
   logic          load;
   logic          shift;
   logic          use_fast;
   logic          ref_wrap;
   logic [12:0]   frame;

`ifdef KBD_LINK_SHIFT_FAST_EN
   logic fast_q;
   assign use_fast = fast_q;
`else
   assign use_fast = 1'b0;
`endif

   assign ref_wrap = (ref_cnt == TW'(REFRESH_CYCLES - 1));

   // GAP is one cycle shorter than the other phases: the IDLE load cycle
   // completes the CLK_DIV-cycle high time of scs_n, keeping the
   // frame period at 29*CLK_DIV.
   always_comb begin
      if (state == S_GAP) tick = (div_cnt == DW'(CLK_DIV - 2));
      else                tick = (div_cnt == DW'(CLK_DIV - 1));
   end

   // Round-robin: first dirty row after ptr; lowest offset wins.
   always_comb begin
      sel_row = ptr;
      for (int unsigned i = 4; i >= 1; i--) begin
         if (dirty_q[2'(ptr + 2'(i))]) sel_row = 2'(ptr + 2'(i));
      end
   end

   always_comb begin
      if (use_fast) frame = {3'b101, 8'b0, key_state[36], key_state[0]};
      else          frame = {1'b0, sel_row, key_state[10*sel_row +: 10]};
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         S_IDLE: begin
            if (use_fast || (|dirty_q)) begin
               load      = 1'b1;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP:  if (tick) state_nxt = S_BIT_HI;
         S_BIT_HI: if (tick) state_nxt = S_BIT_LO;
         S_BIT_LO: begin
            if (tick) begin
               shift     = 1'b1;
               state_nxt = (bit_cnt == 4'd12) ? S_END : S_BIT_HI;
            end
         end
         S_END:    if (tick) state_nxt = S_GAP;
         S_GAP:    if (tick) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign scs_n = (state == S_IDLE) || (state == S_GAP);
   assign sclk  = (state != S_BIT_LO);
   assign sdata = (state == S_IDLE) ? 1'b0 : shreg[12];
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         shadow       <= '0;
         refresh_pend <= '1;
         dirty_q      <= '0;
         ref_cnt      <= '0;
         ptr          <= 2'd3;
`ifdef KBD_LINK_SHIFT_FAST_EN
         fast_q       <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == S_IDLE || state_nxt != state) div_cnt <= '0;
         else                                       div_cnt <= div_cnt + 1'b1;

         ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

         for (int unsigned r = 0; r < 4; r++) begin
            dirty_q[r] <= (key_state[10*r +: 10] != shadow[10*r +: 10]) | refresh_pend[r];
         end
`ifdef KBD_LINK_SHIFT_FAST_EN
         fast_q <= (key_state[0] != shadow[0]) | (key_state[36] != shadow[36]);
`endif

         if (load) begin
            shreg   <= frame;
            bit_cnt <= '0;
            if (use_fast) begin
               shadow[0]  <= key_state[0];
               shadow[36] <= key_state[36];
            end else begin
               shadow[10*sel_row +: 10] <= key_state[10*sel_row +: 10];
               refresh_pend[sel_row]    <= 1'b0;
               ptr                      <= sel_row;
            end
         end else if (shift) begin
            shreg   <= {shreg[11:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
         end

         // Placed after the load clear so a coinciding wrap wins.
         if (ref_wrap) refresh_pend <= '1;
      end
   end

endmodule

// File: tb/tb_kbd_link_tx.sv
// tb_kbd_link_tx: self-checking bench for kbd_link_tx. A link monitor
// reassembles frames into a queue; tests push expected frames from a small
// key-matrix model and compare as frames arrive.
module tb_kbd_link_tx;

   localparam int unsigned CLK_DIV = 4;

   typedef struct {
      logic [12:0] frame;
      int          falls;
      int          low;
      int          start;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] keys = '0;
   logic        scs_n, sclk, sdata, busy;

   int n_checks = 0;
   int n_fail   = 0;

   rec_t        obs_q[$];
   logic [12:0] exp_q[$];

   int  cyc = 0;
   int  mon_falls = 0;
   bit  in_frame = 0;
   int  viol = 0;

   kbd_link_tx #(.CLK_DIV(CLK_DIV), .REFRESH_CYCLES(1000000)) dut (
      .clk(clk), .rst(rst), .key_state(keys),
      .scs_n(scs_n), .sclk(sclk), .sdata(sdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Link monitor, sampling on the falling clk edge.
   initial begin
      logic        p_scs, p_sclk, p_sd;
      logic [12:0] sr;
      int          low, start;
      p_scs = 1'b1; p_sclk = 1'b1; p_sd = 1'b0; sr = '0; low = 0; start = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            in_frame  = 0;
            mon_falls = 0;
         end else begin
            if (!scs_n && p_scs) begin
               in_frame = 1; sr = '0; mon_falls = 0; low = 0; start = cyc;
            end
            if (!sclk && !p_sclk && sdata !== p_sd) viol++;
            if (in_frame) begin
               if (!scs_n) low++;
               if (p_sclk && !sclk && !scs_n) begin
                  sr = {sr[11:0], sdata};
                  mon_falls++;
               end
               if (scs_n) begin
                  obs_q.push_back('{frame: sr, falls: mon_falls, low: low, start: start});
                  in_frame = 0;
               end
            end
         end
         p_scs = scs_n; p_sclk = sclk; p_sd = sdata;
      end
   end

   function automatic logic [12:0] exp_row(int r);
      logic [2:0] id;
      id = 3'(r);
      return {id, keys[10*r +: 10]};
   endfunction

   function automatic logic [12:0] exp_fast();
      return {3'b101, 8'b0, keys[36], keys[0]};
   endfunction

   task automatic get_frame(output rec_t r, output bit ok);
      ok = 0;
      for (int i = 0; i < 2000 && obs_q.size() == 0; i++) @(posedge clk);
      if (obs_q.size() > 0) begin
         r  = obs_q.pop_front();
         ok = 1;
      end else begin
         r = '{frame: 'x, falls: 0, low: 0, start: 0};
      end
   endtask

   task automatic test_reset();
      rec_t r; bit ok; int prev; logic [12:0] e;
      rst = 1'b1; keys = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (scs_n !== 1'b1) begin n_fail++; $display("FAIL rst_scs_n got=%b exp=1", scs_n); end
      n_checks++; if (sclk  !== 1'b1) begin n_fail++; $display("FAIL rst_sclk got=%b exp=1", sclk); end
      n_checks++; if (sdata !== 1'b0) begin n_fail++; $display("FAIL rst_sdata got=%b exp=0", sdata); end
      n_checks++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_row(k));
      rst = 1'b0;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         get_frame(r, ok);
         e = exp_q.pop_front();
         n_checks++; if (!ok) begin n_fail++; $display("FAIL refresh_timeout frame=%0d", k); end
         n_checks++; if (r.frame !== e) begin n_fail++; $display("FAIL refresh_frame got=%h exp=%h", r.frame, e); end
         n_checks++; if (r.falls != 13) begin n_fail++; $display("FAIL refresh_falls got=%0d exp=13", r.falls); end
         n_checks++; if (r.low != 28*CLK_DIV) begin n_fail++; $display("FAIL refresh_low got=%0d exp=%0d", r.low, 28*CLK_DIV); end
         if (k > 0) begin
            n_checks++;
            if (r.start - prev != 29*CLK_DIV) begin
               n_fail++; $display("FAIL frame_period got=%0d exp=%0d", r.start - prev, 29*CLK_DIV);
            end
         end
         prev = r.start;
      end
      repeat (CLK_DIV + 2) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
      repeat (400) @(posedge clk);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL refresh_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_two_rows();
      rec_t r; bit ok; logic [12:0] e;
      @(posedge clk); #1;
      keys[5] = 1'b1; keys[25] = 1'b1;
      exp_q.push_back(exp_row(0));
      exp_q.push_back(exp_row(2));
      for (int k = 0; k < 2; k++) begin
         get_frame(r, ok);
         e = exp_q.pop_front();
         n_checks++; if (!ok || r.frame !== e) begin n_fail++; $display("FAIL two_rows got=%h exp=%h ok=%0d", r.frame, e, ok); end
      end
      repeat (400) @(posedge clk);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL two_rows_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_single_key();
      rec_t r; bit ok; logic [12:0] e;
      @(posedge clk); #1;
      keys[12] = 1'b1;
      exp_q.push_back(exp_row(1));
      @(posedge clk); #1;
      n_checks++; if (scs_n !== 1'b1) begin n_fail++; $display("FAIL latency_1 got=%b exp=1", scs_n); end
      @(posedge clk); #1;
      n_checks++; if (scs_n !== 1'b0) begin n_fail++; $display("FAIL latency_2 got=%b exp=0", scs_n); end
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || r.frame !== e) begin n_fail++; $display("FAIL single_key got=%h exp=%h ok=%0d", r.frame, e, ok); end
      repeat (400) @(posedge clk);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_key_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_key36();
      rec_t r; bit ok; logic [12:0] e;
      @(posedge clk); #1;
      keys[36] = 1'b1;
`ifdef KBD_LINK_SHIFT_FAST_EN
      exp_q.push_back(exp_fast());
`else
      exp_q.push_back(exp_row(3));
`endif
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_checks++; if (!ok || r.frame !== e) begin n_fail++; $display("FAIL key36 got=%h exp=%h ok=%0d", r.frame, e, ok); end
      repeat (400) @(posedge clk);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL key36_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_reset_mid();
      rec_t r; bit ok; logic [12:0] e; int n;
      @(posedge clk); #1;
      keys[1] = 1'b1;
      for (int i = 0; i < 2000 && !(in_frame && mon_falls >= 6); i++) @(posedge clk);
      n_checks++; if (!(in_frame && mon_falls >= 6)) begin n_fail++; $display("FAIL mid_frame_timeout falls=%0d exp=6", mon_falls); end
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (scs_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_scs_n got=%b exp=1", scs_n); end
      n_checks++; if (sclk  !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sclk got=%b exp=1", sclk); end
      n_checks++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
      obs_q.delete();
      exp_q.delete();
`ifdef KBD_LINK_SHIFT_FAST_EN
      exp_q.push_back(exp_fast());
`endif
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_row(k));
      n = exp_q.size();
      rst = 1'b0;
      for (int k = 0; k < n; k++) begin
         get_frame(r, ok);
         e = exp_q.pop_front();
         n_checks++; if (!ok || r.frame !== e) begin n_fail++; $display("FAIL post_rst got=%h exp=%h ok=%0d", r.frame, e, ok); end
         n_checks++; if (r.falls != 13) begin n_fail++; $display("FAIL post_rst_falls got=%0d exp=13", r.falls); end
      end
      repeat (400) @(posedge clk);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL post_rst_extra got=%0d exp=0", obs_q.size()); end
      n_checks++; if (viol != 0) begin n_fail++; $display("FAIL sdata_while_sclk_low got=%0d exp=0", viol); end
   endtask

   initial begin
      test_reset();
      test_two_rows();
      test_single_key();
      test_key36();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
